// File: rtl/univ_fifo_pkg.sv
// Shared constants and types for the univ_sync_fifo read-side drain stage.
package univ_fifo_pkg;
  localparam int unsigned BUF_DEPTH      = 2;
  localparam int unsigned DEF_DATA_WIDTH = 32;
  localparam int unsigned DEF_CNT_WIDTH  = 16;

  // Buffer occupancy, 0..BUF_DEPTH
  typedef logic [1:0] occ_t;
endpackage

// File: rtl/univ_fifo_rd_stream_if.sv
// Valid/ready stream bus driven by the FIFO drain stage.
interface univ_fifo_rd_stream_if
  import univ_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) ();
  logic                  m_valid;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_ready;

  modport master (output m_valid, output m_data, input  m_ready);
  modport slave  (input  m_valid, input  m_data, output m_ready);
endinterface

// File: rtl/univ_fifo_skid_buf.sv
// Two-entry register buffer; entry 0 is always the head of the queue.
module univ_fifo_skid_buf
  import univ_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  rd,
  output logic [DATA_WIDTH-1:0] head,
  output occ_t                  occ
);
  logic [DATA_WIDTH-1:0] ent0;
  logic [DATA_WIDTH-1:0] ent1;

  // Callers never write when full without reading, nor read when empty.
  always_ff @(posedge clk) begin
    if (rst) begin
      ent0 <= '0;
      ent1 <= '0;
      occ  <= '0;
    end else begin
      case ({wr, rd})
        2'b10: begin
          if (occ == '0) ent0 <= wdata;
          else           ent1 <= wdata;
          occ <= occ + 2'd1;
        end
        2'b01: begin
          ent0 <= ent1;
          occ  <= occ - 2'd1;
        end
        2'b11: begin
          // Head advances; the new word lands behind whatever remains.
          if (occ == 2'd2) begin
            ent0 <= ent1;
            ent1 <= wdata;
          end else begin
            ent0 <= wdata;
          end
        end
        default: ;
      endcase
    end
  end

  assign head = ent0;
endmodule

// File: rtl/univ_fifo_rd_stream.sv
// Drains univ_sync_fifo (1-cycle read latency) onto a valid/ready stream
// through a 2-entry buffer, counting delivered words.
module univ_fifo_rd_stream
  import univ_fifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  output logic                  fifo_cs,
  output logic                  fifo_rd_en,
  input  logic [DATA_WIDTH-1:0] fifo_data_out,
  input  logic                  fifo_empty,
  univ_fifo_rd_stream_if.master m,
  output logic [CNT_WIDTH-1:0]  word_cnt,
  output logic                  busy
);
  logic                  inflight;
  logic                  pop;
  occ_t                  occ;
  logic [DATA_WIDTH-1:0] head;
  logic [2:0]            committed;

  assign pop = m.m_valid & m.m_ready;

  // Slots already claimed once this cycle's pop leaves; a read may only
  // be issued if a slot will be free when its data arrives.
  assign committed  = {1'b0, occ} + {2'b00, inflight} - {2'b00, pop};
  assign fifo_rd_en = en & ~fifo_empty & ~rst & (committed < 3'(BUF_DEPTH));
  assign fifo_cs    = fifo_rd_en;

  always_ff @(posedge clk) begin
    if (rst) begin
      inflight <= 1'b0;
      word_cnt <= '0;
    end else begin
      inflight <= fifo_rd_en;
      if (pop) word_cnt <= word_cnt + 1'b1;
    end
  end

  univ_fifo_skid_buf #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_buf (
    .clk   (clk),
    .rst   (rst),
    .wr    (inflight),
    .wdata (fifo_data_out),
    .rd    (pop),
    .head  (head),
    .occ   (occ)
  );

  assign m.m_valid = (occ != '0);
  assign m.m_data  = head;
  assign busy      = (occ != '0) | inflight;
endmodule

// File: tb/tb_univ_fifo_rd_stream.sv
// Self-checking bench for univ_fifo_rd_stream against a behavioural FIFO model.
module tb_univ_fifo_rd_stream;
  localparam int unsigned DW = 32;
  localparam int unsigned CW = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          en;
  logic          fifo_cs;
  logic          fifo_rd_en;
  logic [DW-1:0] fifo_data_out;
  logic          fifo_empty;
  logic [CW-1:0] word_cnt;
  logic          busy;

  int tests = 0;
  int fails = 0;

  logic [DW-1:0] fifo_q[$];
  logic [DW-1:0] exp_q[$];

  univ_fifo_rd_stream_if #(.DATA_WIDTH(DW)) s ();

  univ_fifo_rd_stream #(
    .DATA_WIDTH (DW),
    .CNT_WIDTH  (CW)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .en            (en),
    .fifo_cs       (fifo_cs),
    .fifo_rd_en    (fifo_rd_en),
    .fifo_data_out (fifo_data_out),
    .fifo_empty    (fifo_empty),
    .m             (s.master),
    .word_cnt      (word_cnt),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  // Behavioural univ_sync_fifo: data appears the cycle after a sampled read.
  always @(posedge clk) begin
    if (rst) begin
      fifo_q.delete();
      fifo_empty    <= 1'b1;
      fifo_data_out <= '0;
    end else if (fifo_rd_en) begin
      if (fifo_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL fifo_underflow: read issued while FIFO model is empty");
      end else begin
        fifo_empty    <= (fifo_q.size() <= 1);
        fifo_data_out <= fifo_q.pop_front();
      end
    end
  end

  // Scoreboard: every accepted word must match the oldest expected word.
  always @(negedge clk) begin
    if (!rst && s.m_valid && s.m_ready) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL stream_extra: got %0h, expected no word", s.m_data);
      end else begin
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        if (s.m_data !== e) begin
          fails++;
          $display("FAIL stream_data: got %0h, expected %0h", s.m_data, e);
        end
      end
    end
  end

  task automatic push_word(input logic [DW-1:0] w);
    fifo_q.push_back(w);
    exp_q.push_back(w);
    fifo_empty = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1; en = 1'b0; s.m_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    tests++; if (s.m_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b, expected 0", s.m_valid); end
    tests++; if (fifo_rd_en !== 1'b0) begin fails++; $display("FAIL reset_rd_en: got %b, expected 0", fifo_rd_en); end
    tests++; if (word_cnt !== '0) begin fails++; $display("FAIL reset_cnt: got %0d, expected 0", word_cnt); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b, expected 0", busy); end
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_single;
    int rd_n = 0, v_n = 0, rd_at = -1, v_at = -1;
    push_word(32'd1);
    en = 1'b1; s.m_ready = 1'b1;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      tests++;
      if (fifo_cs !== fifo_rd_en) begin fails++; $display("FAIL cs_eq_rd_en: cs %b, rd_en %b", fifo_cs, fifo_rd_en); end
      if (fifo_rd_en) begin rd_n++; if (rd_at < 0) rd_at = c; end
      if (s.m_valid) begin v_n++; if (v_at < 0) v_at = c; end
    end
    tests++; if (rd_n != 1) begin fails++; $display("FAIL single_reads: got %0d, expected 1", rd_n); end
    tests++; if (v_n != 1) begin fails++; $display("FAIL single_valid: got %0d cycles, expected 1", v_n); end
    tests++; if (v_at - rd_at != 2) begin fails++; $display("FAIL single_latency: got %0d, expected 2", v_at - rd_at); end
    tests++; if (word_cnt !== 4'd1) begin fails++; $display("FAIL single_cnt: got %0d, expected 1", word_cnt); end
    @(posedge clk); #1;
  endtask

  task automatic test_burst;
    int rd_n = 0, rd_f = -1, rd_l = -1, v_n = 0, v_f = -1, v_l = -1;
    for (int i = 0; i < 8; i++) push_word(32'd1 << i);
    en = 1'b1; s.m_ready = 1'b1;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (fifo_rd_en) begin rd_n++; if (rd_f < 0) rd_f = c; rd_l = c; end
      if (s.m_valid) begin v_n++; if (v_f < 0) v_f = c; v_l = c; end
    end
    tests++; if (rd_n != 8 || rd_l - rd_f != 7) begin fails++; $display("FAIL burst_reads: got %0d over span %0d, expected 8 over 7", rd_n, rd_l - rd_f); end
    tests++; if (v_n != 8 || v_l - v_f != 7) begin fails++; $display("FAIL burst_valid: got %0d over span %0d, expected 8 over 7", v_n, v_l - v_f); end
    tests++; if (word_cnt !== 4'd9) begin fails++; $display("FAIL burst_cnt: got %0d, expected 9", word_cnt); end
    tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL burst_drain: got %0d left, expected 0", exp_q.size()); end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure;
    int rd_n = 0, v_n = 0;
    bit gap = 0;
    for (int i = 0; i < 8; i++) push_word(32'd1 << i);
    en = 1'b1; s.m_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (fifo_rd_en) rd_n++;
      if (c >= 2) begin
        tests++;
        if (s.m_valid !== 1'b1 || s.m_data !== 32'd1) begin
          fails++;
          $display("FAIL bp_hold: got valid %b data %0h, expected valid 1 data 1", s.m_valid, s.m_data);
        end
      end
    end
    tests++; if (rd_n != 2) begin fails++; $display("FAIL bp_reads: got %0d, expected 2", rd_n); end
    @(posedge clk); #1;
    s.m_ready = 1'b1;
    for (int c = 0; c < 14; c++) begin
      @(negedge clk);
      if (s.m_valid) begin
        if (v_n != c) gap = 1;
        v_n++;
      end
    end
    tests++; if (v_n != 8 || gap) begin fails++; $display("FAIL bp_drain: got %0d words gap %0d, expected 8 gap 0", v_n, gap); end
    tests++; if (exp_q.size() != 0) begin fails++; $display("FAIL bp_left: got %0d left, expected 0", exp_q.size()); end
    // 17 words delivered since reset on a 4-bit counter
    tests++; if (word_cnt !== 4'd1) begin fails++; $display("FAIL bp_cnt: got %0d, expected 1", word_cnt); end
    @(posedge clk); #1;
  endtask

  task automatic test_enable;
    int rd_n = 0, v_n = 0;
    for (int i = 0; i < 3; i++) push_word(32'hA0 + i);
    en = 1'b0; s.m_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (fifo_rd_en) rd_n++;
      if (s.m_valid) v_n++;
    end
    tests++; if (rd_n != 0 || v_n != 0) begin fails++; $display("FAIL en_off: got %0d reads %0d valid, expected 0 0", rd_n, v_n); end
    @(posedge clk); #1;
    en = 1'b1; s.m_ready = 1'b0; rd_n = 0;
    for (int c = 0; c < 4; c++) begin @(negedge clk); if (fifo_rd_en) rd_n++; end
    tests++; if (rd_n != 2) begin fails++; $display("FAIL en_fill: got %0d reads, expected 2", rd_n); end
    @(posedge clk); #1;
    en = 1'b0; s.m_ready = 1'b1; rd_n = 0; v_n = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (fifo_rd_en) rd_n++;
      if (s.m_valid) v_n++;
    end
    tests++; if (rd_n != 0 || v_n != 2) begin fails++; $display("FAIL en_drain: got %0d reads %0d words, expected 0 2", rd_n, v_n); end
    @(posedge clk); #1;
    en = 1'b1; rd_n = 0;
    for (int c = 0; c < 6; c++) begin @(negedge clk); if (fifo_rd_en) rd_n++; end
    tests++; if (rd_n != 1 || exp_q.size() != 0) begin fails++; $display("FAIL en_resume: got %0d reads %0d left, expected 1 0", rd_n, exp_q.size()); end
    @(posedge clk); #1;
    rd_n = 0;
    for (int c = 0; c < 5; c++) begin @(negedge clk); if (fifo_rd_en) rd_n++; end
    tests++; if (rd_n != 0) begin fails++; $display("FAIL empty_no_read: got %0d reads, expected 0", rd_n); end
    @(posedge clk); #1;
  endtask

  task automatic test_reset_mid;
    int v_n, rd_n;
    for (int variant = 0; variant < 2; variant++) begin
      for (int i = 0; i < 4 + 2 * variant; i++) push_word(32'hC000 + 16 * variant + i);
      en = 1'b1; s.m_ready = (variant == 1);
      repeat (3 + (variant == 0)) @(negedge clk);
      tests++; if (busy !== 1'b1) begin fails++; $display("FAIL rstmid_busy_pre v%0d: got %b, expected 1", variant, busy); end
      @(posedge clk); #1;
      rst = 1'b1;
      exp_q.delete();
      @(negedge clk);
      tests++; if (fifo_rd_en !== 1'b0) begin fails++; $display("FAIL rstmid_rd_en v%0d: got %b, expected 0", variant, fifo_rd_en); end
      @(posedge clk); #1;
      tests++;
      if (s.m_valid !== 1'b0 || word_cnt !== '0 || busy !== 1'b0) begin
        fails++;
        $display("FAIL rstmid_state v%0d: got valid %b cnt %0d busy %b, expected 0 0 0", variant, s.m_valid, word_cnt, busy);
      end
      rst = 1'b0; s.m_ready = 1'b1;
      v_n = 0; rd_n = 0;
      for (int c = 0; c < 6; c++) begin
        @(negedge clk);
        if (s.m_valid) v_n++;
        if (fifo_rd_en) rd_n++;
      end
      tests++; if (v_n != 0 || rd_n != 0) begin fails++; $display("FAIL rstmid_stale v%0d: got %0d words %0d reads, expected 0 0", variant, v_n, rd_n); end
      @(posedge clk); #1;
    end
  endtask

  task automatic test_wrap;
    int c;
    for (int i = 0; i < 17; i++) push_word(32'h5000 + i);
    en = 1'b1; s.m_ready = 1'b1;
    for (c = 0; c < 40 && !(exp_q.size() == 0 && busy === 1'b0); c++) @(negedge clk);
    tests++; if (c >= 40) begin fails++; $display("FAIL wrap_timeout: %0d words still pending, expected 0", exp_q.size()); end
    tests++; if (word_cnt !== 4'd1) begin fails++; $display("FAIL wrap_cnt: got %0d, expected 1", word_cnt); end
    @(posedge clk); #1;
  endtask

  initial begin
    fifo_empty = 1'b1;
    test_reset();
    test_single();
    test_burst();
    test_backpressure();
    test_enable();
    test_reset_mid();
    test_wrap();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
    $fatal(1);
  end
endmodule
